// File: rtl/arty_reset_sequencer.sv
// Purpose: staged reset release for the Arty A7 core domain, gated on MMCM lock.
// Latency: channel k released P_SYNC_STAGES + P_HOLD_CYCLES + k*P_STAGGER_CYCLES edges after lock is first sampled high.
// Backpressure: none; free-running sequencer with no handshake.
//
// Ports:
//   i_clk_mhz      single clock, all logic on its rising edge
//   i_rstn_global  synchronous active-low reset, overrides everything
//   i_mmcm_locked  raw MMCM lock, asynchronous, synchronized internally
//   i_sw_rst       single-cycle software reset request
//   o_rst_mhz      per-channel active-high resets (registered)
//   o_rst_done     high once every channel is released (registered)
//
// Build option: define RESET_SEQ_LOCK_TRACK_EN to re-assert all channels
// whenever the synchronized lock drops after leaving the lock-wait state.
module arty_reset_sequencer #(
    parameter int P_CHANNELS       = 3,
    parameter int P_SYNC_STAGES    = 2,
    parameter int P_HOLD_CYCLES    = 14,
    parameter int P_STAGGER_CYCLES = 4
) (
    input  logic                  i_clk_mhz,
    input  logic                  i_rstn_global,
    input  logic                  i_mmcm_locked,
    input  logic                  i_sw_rst,
    output logic [P_CHANNELS-1:0] o_rst_mhz,
    output logic                  o_rst_done
);

    localparam int MAX_CNT = (P_HOLD_CYCLES > P_STAGGER_CYCLES) ? P_HOLD_CYCLES : P_STAGGER_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(P_CHANNELS + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(P_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(P_STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(P_CHANNELS - 1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STRETCH   = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    logic [P_SYNC_STAGES-1:0] sync_q;
    logic                     s_locked;
    logic [1:0]               state;
    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;
    logic [P_CHANNELS-1:0]    idx_mask;
    logic                     lock_lost;

    assign s_locked = sync_q[P_SYNC_STAGES-1];

    // One-hot select of the channel that the next stagger expiry releases.
    always_comb begin
        idx_mask = '0;
        for (int i = 0; i < P_CHANNELS; i++) begin
            idx_mask[i] = (idx == IW'(i));
        end
    end

`ifdef RESET_SEQ_LOCK_TRACK_EN
    // Any drop of the synchronized lock after lock-wait restarts the sequence.
    assign lock_lost = (state != ST_WAIT_LOCK) && !s_locked;
`else
    // Lock is only consulted while waiting for it.
    assign lock_lost = 1'b0;
`endif

    always_ff @(posedge i_clk_mhz) begin
        if (!i_rstn_global) begin
            state      <= ST_WAIT_LOCK;
            sync_q     <= '0;
            cnt        <= '0;
            idx        <= '0;
            o_rst_mhz  <= '1;
            o_rst_done <= 1'b0;
        end else begin
            sync_q <= {sync_q[P_SYNC_STAGES-2:0], i_mmcm_locked};

            // Lock loss takes priority over a coincident software request.
            if (lock_lost) begin
                state      <= ST_WAIT_LOCK;
                cnt        <= '0;
                idx        <= '0;
                o_rst_mhz  <= '1;
                o_rst_done <= 1'b0;
            end else if (i_sw_rst && (state != ST_WAIT_LOCK)) begin
                state      <= ST_STRETCH;
                cnt        <= '0;
                idx        <= '0;
                o_rst_mhz  <= '1;
                o_rst_done <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_LOCK: begin
                        o_rst_mhz  <= '1;
                        o_rst_done <= 1'b0;
                        if (s_locked) begin
                            state <= ST_STRETCH;
                            cnt   <= '0;
                        end
                    end
                    ST_STRETCH: begin
                        if (cnt == HOLD_LAST) begin
                            // Channel 0 is released on the same edge the hold expires.
                            o_rst_mhz[0] <= 1'b0;
                            cnt          <= '0;
                            idx          <= IW'(1);
                            if (P_CHANNELS == 1) begin
                                state      <= ST_RUN;
                                o_rst_done <= 1'b1;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt == STAG_LAST) begin
                            o_rst_mhz <= o_rst_mhz & ~idx_mask;
                            cnt       <= '0;
                            idx       <= idx + 1'b1;
                            if (idx == IDX_LAST) begin
                                state      <= ST_RUN;
                                o_rst_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        o_rst_mhz  <= '0;
                        o_rst_done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arty_reset_sequencer.sv
// Purpose: self-checking bench for arty_reset_sequencer (3-channel default and 1-channel/hold-1 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_arty_reset_sequencer;

    logic i_clk_mhz = 1'b0;
    always #5 i_clk_mhz = ~i_clk_mhz;

    logic       i_rstn_global;
    logic       i_mmcm_locked;
    logic       i_sw_rst;
    logic [2:0] rst_a;
    logic       done_a;
    logic [0:0] rst_b;
    logic       done_b;

`ifdef RESET_SEQ_LOCK_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    arty_reset_sequencer #(
        .P_CHANNELS(3), .P_SYNC_STAGES(2), .P_HOLD_CYCLES(14), .P_STAGGER_CYCLES(4)
    ) dut_a (
        .i_clk_mhz(i_clk_mhz), .i_rstn_global(i_rstn_global), .i_mmcm_locked(i_mmcm_locked),
        .i_sw_rst(i_sw_rst), .o_rst_mhz(rst_a), .o_rst_done(done_a)
    );

    arty_reset_sequencer #(
        .P_CHANNELS(1), .P_SYNC_STAGES(2), .P_HOLD_CYCLES(1), .P_STAGGER_CYCLES(4)
    ) dut_b (
        .i_clk_mhz(i_clk_mhz), .i_rstn_global(i_rstn_global), .i_mmcm_locked(i_mmcm_locked),
        .i_sw_rst(i_sw_rst), .o_rst_mhz(rst_b), .o_rst_done(done_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read at the next falling edge.
    task automatic tick();
        @(negedge i_clk_mhz);
    endtask

    // ---------------- timestamp reference model ----------------
    // Each sequence is described by the edge T at which stretching began;
    // channel k is released from edge T + hold + k*stagger on.
    function automatic int p_ch(input int d);   return (d == 0) ? 3 : 1;  endfunction
    function automatic int p_hold(input int d); return (d == 0) ? 14 : 1; endfunction
    localparam int SYNC = 2;
    localparam int STG  = 4;

    bit raw_hist [0:16383];
    int ne       = 0;
    int last_rst = -1000;
    bit m_wait [2];
    int m_t    [2];

    always @(posedge i_clk_mhz) begin : model
        bit sl;
        raw_hist[ne] = i_mmcm_locked;
        if (!i_rstn_global) begin
            last_rst  = ne;
            m_wait[0] = 1'b1;
            m_wait[1] = 1'b1;
        end else begin
            // Lock seen by the sequencer at edge ne is the raw value sampled SYNC edges earlier,
            // provided that sample was taken after the last reset.
            sl = (ne - SYNC > last_rst) && (ne - SYNC >= 0) && raw_hist[ne - SYNC];
            for (int d = 0; d < 2; d++) begin
                if (m_wait[d]) begin
                    if (sl) begin
                        m_wait[d] = 1'b0;
                        m_t[d]    = ne;
                    end
                end else if (TRACK && !sl) begin
                    m_wait[d] = 1'b1;
                end else if (i_sw_rst) begin
                    m_t[d] = ne;
                end
            end
        end
        ne++;
    end

    function automatic logic [2:0] m_rst(input int d);
        logic [2:0] r;
        int e;
        e = ne - 1;
        r = '0;
        for (int k = 0; k < p_ch(d); k++)
            r[k] = m_wait[d] || (e < m_t[d] + p_hold(d) + k * STG);
        return r;
    endfunction

    function automatic logic m_done(input int d);
        int e;
        e = ne - 1;
        return !m_wait[d] && (e >= m_t[d] + p_hold(d) + (p_ch(d) - 1) * STG);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        int         n;
        bit         rstn;
        bit         lock;
        bit         sw;
        logic [2:0] rst;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input bit rstn, input bit lock, input bit sw,
                                input logic [2:0] rst, input logic done);
        vec_t v;
        v.n = n; v.rstn = rstn; v.lock = lock; v.sw = sw; v.rst = rst; v.done = done;
        tbl.push_back(v);
    endfunction

    logic [2:0] exp3;

    initial begin
        i_rstn_global = 1'b0;
        i_mmcm_locked = 1'b0;
        i_sw_rst      = 1'b0;

        // power-up: 5 reset cycles, then lock sampled high from E0
        add(5,  0, 0, 0, 3'b111, 0);
        add(16, 1, 1, 0, 3'b111, 0);   // E0..E15
        add(1,  1, 1, 0, 3'b110, 0);   // E16
        add(3,  1, 1, 0, 3'b110, 0);
        add(1,  1, 1, 0, 3'b100, 0);   // E20
        add(3,  1, 1, 0, 3'b100, 0);
        add(1,  1, 1, 0, 3'b000, 1);   // E24
        add(5,  1, 1, 0, 3'b000, 1);
        // software reset in run
        add(1,  1, 1, 1, 3'b111, 0);   // S
        add(13, 1, 1, 0, 3'b111, 0);
        add(1,  1, 1, 0, 3'b110, 0);   // S+14
        add(3,  1, 1, 0, 3'b110, 0);
        add(1,  1, 1, 0, 3'b100, 0);   // S+18
        add(3,  1, 1, 0, 3'b100, 0);
        add(1,  1, 1, 0, 3'b000, 1);   // S+22
        // software reset one edge after channel 0 releases
        add(1,  1, 1, 1, 3'b111, 0);
        add(13, 1, 1, 0, 3'b111, 0);
        add(1,  1, 1, 0, 3'b110, 0);   // R
        add(1,  1, 1, 1, 3'b111, 0);   // R+1
        add(13, 1, 1, 0, 3'b111, 0);
        add(1,  1, 1, 0, 3'b110, 0);   // R+15
        add(3,  1, 1, 0, 3'b110, 0);
        add(1,  1, 1, 0, 3'b100, 0);   // R+19
        add(3,  1, 1, 0, 3'b100, 0);
        add(1,  1, 1, 0, 3'b000, 1);   // R+23

        foreach (tbl[i]) begin
            i_rstn_global = tbl[i].rstn;
            i_mmcm_locked = tbl[i].lock;
            i_sw_rst      = tbl[i].sw;
            for (int j = 0; j < tbl[i].n; j++) begin
                tick();
                chk($sformatf("tbl%0d_rst", i), 32'(rst_a), 32'(tbl[i].rst));
                chk($sformatf("tbl%0d_done", i), 32'(done_a), 32'(tbl[i].done));
            end
        end

        // lock loss while running
        i_mmcm_locked = 1'b0;
        for (int l = 0; l < 7; l++) begin
            tick();
            if (TRACK && l >= 2) begin
                chk($sformatf("lockloss_rst_L%0d", l), 32'(rst_a), 32'h7);
                chk($sformatf("lockloss_done_L%0d", l), 32'(done_a), 32'h0);
            end else begin
                chk($sformatf("lockloss_rst_L%0d", l), 32'(rst_a), 32'h0);
                chk($sformatf("lockloss_done_L%0d", l), 32'(done_a), 32'h1);
            end
        end
        // lock restored: release repeats relative to the new rise
        i_mmcm_locked = 1'b1;
        for (int e = 0; e <= 24; e++) begin
            tick();
            if (!TRACK)      exp3 = 3'b000;
            else if (e < 16) exp3 = 3'b111;
            else if (e < 20) exp3 = 3'b110;
            else if (e < 24) exp3 = 3'b100;
            else             exp3 = 3'b000;
            chk($sformatf("relock_rst_E%0d", e), 32'(rst_a), 32'(exp3));
            chk($sformatf("relock_done_E%0d", e), 32'(done_a), 32'(exp3 == 3'b000));
        end

        // single channel, hold 1: release and done at E3
        i_rstn_global = 1'b0;
        i_mmcm_locked = 1'b0;
        repeat (3) tick();
        chk("single_reset_rst", 32'(rst_b), 32'h1);
        chk("single_reset_done", 32'(done_b), 32'h0);
        i_rstn_global = 1'b1;
        i_mmcm_locked = 1'b1;
        for (int e = 0; e <= 3; e++) begin
            tick();
            chk($sformatf("single_rst_E%0d", e), 32'(rst_b), 32'(e < 3));
            chk($sformatf("single_done_E%0d", e), 32'(done_b), 32'(e >= 3));
        end
        // collision: software request on the edge where lock loss is seen
        i_mmcm_locked = 1'b0;
        for (int l = 0; l < 2; l++) begin
            tick();
            chk($sformatf("coll_pre_rst_L%0d", l), 32'(rst_b), 32'h0);
        end
        i_sw_rst = 1'b1;
        tick();
        chk("coll_rst_L2", 32'(rst_b), 32'h1);
        chk("coll_done_L2", 32'(done_b), 32'h0);
        i_sw_rst = 1'b0;
        for (int l = 3; l < 7; l++) begin
            tick();
            chk($sformatf("coll_rst_L%0d", l), 32'(rst_b), 32'(TRACK));
            chk($sformatf("coll_done_L%0d", l), 32'(done_b), 32'(!TRACK));
        end

        // randomized run against the timestamp model
        for (int c = 0; c < 4000; c++) begin
            i_rstn_global = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 149) == 0) i_mmcm_locked = ~i_mmcm_locked;
            i_sw_rst = ($urandom_range(0, 49) == 0);
            tick();
            chk("rand_rst_a", 32'(rst_a), 32'(m_rst(0)));
            chk("rand_done_a", 32'(done_a), 32'(m_done(0)));
            chk("rand_rst_b", 32'(rst_b), 32'(m_rst(1)));
            chk("rand_done_b", 32'(done_b), 32'(m_done(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arty_reset_sequencer.md
# arty_reset_sequencer

Parametrised reset sequencer for the Arty A7 design: holds a configurable number of downstream reset channels asserted until the MMCM reports lock and a minimum hold time elapses, then releases the channels one at a time in index order with a fixed stagger. It sits directly after the board reset/clock block and drives the active-high resets of the SPI, UART and tester subsystems in the same clock domain. Unlike the plain shift-register reset synchronizer, it gates release on clock lock and supports a software-requested reset. With lock tracking compiled in, it also re-asserts all resets when lock is lost.

## Interface
- P_CHANNELS, 3, number of reset channels; legal range 1..16.
- P_SYNC_STAGES, 2, flops in the `i_mmcm_locked` synchronizer; must be at least 2.
- P_HOLD_CYCLES, 14, cycles spent in ST_STRETCH before channel 0 is released; must be at least 1.
- P_STAGGER_CYCLES, 4, cycles between consecutive channel releases; must be at least 1.

Ports:
- i_clk_mhz  input  1  the single clock; all logic is on its rising edge.
- i_rstn_global  input  1  reset; synchronous, active-low. It is sampled only on the rising edge of `i_clk_mhz`.
- i_mmcm_locked  input  1  MMCM lock; asynchronous to the block and synchronized internally.
- i_sw_rst  input  1  software reset request; synchronous, active-high, single-cycle pulse.
- o_rst_mhz  output  P_CHANNELS  per-channel active-high reset; registered.
- o_rst_done  output  1  high when every channel is released; registered.

## Operation
- **Global reset.** While `i_rstn_global` = 0 at a clock edge:
  - state becomes ST_WAIT_LOCK;
  - `o_rst_mhz` is all ones and `o_rst_done` = 0;
  - the synchronizer flops, the counter and the channel index are all cleared to 0.
- Global reset overrides every other input.
- **ST_WAIT_LOCK.** All channels asserted. When the synchronized lock `s_locked` = 1, go to ST_STRETCH with the counter at 0.
- **ST_STRETCH.** All channels asserted; the counter increments each cycle. At the edge where count = P_HOLD_CYCLES-1:
  - go to ST_RELEASE;
  - deassert `o_rst_mhz[0]` at that same edge;
  - set the channel index to 1 and clear the counter.
- **ST_RELEASE.** The counter increments. At the edge where count = P_STAGGER_CYCLES-1:
  - deassert `o_rst_mhz[index]`;
  - increment the index and clear the counter.
- **Entering ST_RUN.** ST_RUN is entered at the edge that releases channel P_CHANNELS-1. At that same edge `o_rst_done` goes to 1.
- **Single channel.** When P_CHANNELS = 1, ST_STRETCH goes directly to ST_RUN.
- **ST_RUN.** All channels are released and `o_rst_done` = 1.
- **Monotonic release.** A released channel stays released until a re-assert event. Every re-assert event asserts all channels and clears `o_rst_done` at the same edge.
- **`i_sw_rst` = 1:**
  - in ST_STRETCH, ST_RELEASE or ST_RUN: re-assert all channels, clear the counter, go to ST_STRETCH;
  - in ST_WAIT_LOCK: ignored.
- **Lock loss.** Lock-loss behaviour is defined under Configuration. When lock loss and `i_sw_rst` occur in the same cycle, lock loss wins and the next state is ST_WAIT_LOCK.
- **Widths.** The counter is `$clog2(max(P_HOLD_CYCLES, P_STAGGER_CYCLES)+1)` bits wide and never wraps. The index is `$clog2(P_CHANNELS+1)` bits wide.

## Timing
- **Lock latency.** Let E0 be the edge where `i_mmcm_locked` is first sampled high. Then `s_locked` = 1 after edge E(P_SYNC_STAGES-1), and the FSM enters ST_STRETCH at edge E(P_SYNC_STAGES).
- **Release edges.** Channel k deasserts at edge E(P_SYNC_STAGES + P_HOLD_CYCLES + k·P_STAGGER_CYCLES).
- **Done edge.** `o_rst_done` rises at the same edge as the release of the last channel.
- **Defaults.** Channel 0 at E16, channel 1 at E20, channel 2 and done at E24.
- **Software reset.** `i_sw_rst` sampled at edge S: all channels asserted after S, entry to ST_STRETCH at S. Channel 0 releases at S + P_HOLD_CYCLES.
- **Global reset release.** After `i_rstn_global` goes high, ST_WAIT_LOCK is active on the next cycle. With lock already stable, channel 0 releases P_SYNC_STAGES + P_HOLD_CYCLES edges after the first edge with `i_rstn_global` = 1.

## Configuration
- Macro: RESET_SEQ_LOCK_TRACK_EN.
- **Defined:** `s_locked` = 0 in ST_STRETCH, ST_RELEASE or ST_RUN returns the FSM to ST_WAIT_LOCK. All channels are asserted and `o_rst_done` cleared at that same edge. Loss of lock is detected P_SYNC_STAGES edges after the raw input falls.
- **Undefined:** lock is consulted only in ST_WAIT_LOCK; later deassertion of `i_mmcm_locked` is ignored. The port remains present in both builds.

## Test plan
- **Power-up, defaults.** Hold `i_rstn_global` = 0 for 5 cycles, release it, raise `i_mmcm_locked` at E0. Required: `o_rst_mhz` = 3'b111 until E16, then 3'b110 at E16, 3'b100 at E20, 3'b000 at E24, with `o_rst_done` = 1 at E24.
- **Software reset in ST_RUN.** Pulse `i_sw_rst` at edge S. Required: 3'b111 and `o_rst_done` = 0 after S, channel 0 released at S+14, all channels released at S+22.
- **Software reset in ST_RELEASE.** Pulse `i_sw_rst` one edge after channel 0 releases. Required: channel 0 re-asserts immediately and the full 14-cycle stretch restarts.
- **Lock loss in ST_RUN, macro defined.** Drop `i_mmcm_locked` in ST_RUN. Required: all channels assert 2 edges later. When lock is restored, release repeats with E16/E20/E24 spacing relative to the new rise.
- **Lock loss, macro undefined.** Drop `i_mmcm_locked` in ST_RUN. Required: outputs stay at 3'b000 and `o_rst_done` stays 1.
- **Single channel and collision.** Run with P_CHANNELS = 1 and P_HOLD_CYCLES = 1: channel 0 and `o_rst_done` rise at E(P_SYNC_STAGES+1) = E3. Then assert `i_sw_rst` and lock loss in the same cycle (macro defined): required next state is ST_WAIT_LOCK, not ST_STRETCH.
